// File: rtl/neuron_alu_pkg.sv
// Shared definitions for the neuron ALU: FSM encoding, default widths and
// the saturation limits of the default accumulator.
package neuron_alu_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_N_INPUTS = 16;
  localparam int DEF_ACC_W    = 20;

  localparam logic signed [DEF_ACC_W-1:0] DEF_SAT_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
  localparam logic signed [DEF_ACC_W-1:0] DEF_SAT_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/neuron_alu_sat_mac.sv
// Combinational signed multiply-accumulate: the 2*DATA_W-bit product is
// sign-extended and added to the accumulator, clamping instead of wrapping.
module sat_mac
  import neuron_alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic signed [DATA_W-1:0] weight_i,
  input  logic signed [DATA_W-1:0] operand_i,
  output logic signed [ACC_W-1:0]  sum_o
);

  localparam int PROD_W = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W:0]    wideSum;

  // One guard bit above the accumulator exposes overflow in either direction
  always_comb begin
    product = weight_i * operand_i;
    wideSum = {acc_i[ACC_W-1], acc_i}
            + {{(ACC_W+1-PROD_W){product[PROD_W-1]}}, product};
    if (wideSum[ACC_W] != wideSum[ACC_W-1]) begin
      sum_o = wideSum[ACC_W] ? SAT_MIN : SAT_MAX;
    end else begin
      sum_o = wideSum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/neuron_alu.sv
// Neuron ALU: walks an operand memory one address per AG_read request,
// accumulating weight*input with saturation, and publishes the sum once
// every N_INPUTS operands.
module neuron_alu
  import neuron_alu_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int N_INPUTS = DEF_N_INPUTS,
  parameter  int ACC_W    = DEF_ACC_W,
  localparam int ADDR_W   = $clog2(N_INPUTS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    AG_rst,
  input  logic                    AG_read,
  input  logic                    ALU_rst,
  input  logic                    ALU_forget,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_rd_en,
  input  logic [2*DATA_W-1:0]     mem_rdata,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    ag_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_INPUTS - 1);

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  accOut_q, accOut_d;
  logic                     outValid_q, outValid_d;
  logic                     agDone_q, agDone_d;

  logic signed [DATA_W-1:0] weight;
  logic signed [DATA_W-1:0] operand;
  logic signed [ACC_W-1:0]  macSum;

  assign weight  = mem_rdata[2*DATA_W-1:DATA_W];
  assign operand = mem_rdata[DATA_W-1:0];

  sat_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_sat_mac (
    .acc_i     (acc_q),
    .weight_i  (weight),
    .operand_i (operand),
    .sum_o     (macSum)
  );

  // Next-state logic; ALU_rst beats AG_rst beats ALU_forget beats normal flow
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    acc_d      = acc_q;
    accOut_d   = accOut_q;
    outValid_d = 1'b0;
    agDone_d   = 1'b0;
    if (ALU_rst) begin
      state_d  = IDLE;
      addr_d   = '0;
      acc_d    = '0;
      accOut_d = '0;
    end else if (AG_rst) begin
      state_d = IDLE;
      addr_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (AG_read) begin
            state_d = FETCH;
          end
        end
        FETCH: begin
          state_d = ACCUM;
        end
        ACCUM: begin
          acc_d = macSum;
          if (addr_q == LAST_ADDR) begin
            addr_d  = '0;
            state_d = DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = IDLE;
          end
        end
        DONE: begin
          accOut_d   = acc_q;
          outValid_d = 1'b1;
          agDone_d   = 1'b1;
          state_d    = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
      if (ALU_forget) begin
        acc_d = '0;
      end
    end
  end

  // State and datapath registers, cleared asynchronously while reset is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      acc_q      <= '0;
      accOut_q   <= '0;
      outValid_q <= 1'b0;
      agDone_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      acc_q      <= acc_d;
      accOut_q   <= accOut_d;
      outValid_q <= outValid_d;
      agDone_q   <= agDone_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_rd_en = (state_q == FETCH);
  assign busy      = (state_q != IDLE);
  assign acc_out   = accOut_q;
  assign out_valid = outValid_q;
  assign ag_done   = agDone_q;

endmodule

// File: tb/tb_neuron_alu.sv
// Self-checking bench for neuron_alu with a 16-bit accumulator so that
// saturation is reachable with 8-bit operands.
module tb_neuron_alu;

  localparam int DATA_W   = 8;
  localparam int N_INPUTS = 16;
  localparam int ACC_W    = 16;

  typedef struct {
    logic signed [7:0]  w;
    logic signed [7:0]  x;
    bit                 ramp;
    logic signed [15:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset, AG_rst, AG_read, ALU_rst, ALU_forget;
  logic [3:0] mem_addr;
  logic mem_rd_en;
  logic [15:0] mem_rdata;
  logic signed [15:0] acc_out;
  logic out_valid, busy, ag_done;

  int checks = 0;
  int errors = 0;
  int outValidCount = 0;
  int agDoneCount = 0;
  int rdEnCount = 0;

  logic signed [15:0] expQ[$];
  logic [15:0] mem [16];
  vec_t vecs[6];

  neuron_alu #(
    .DATA_W   (DATA_W),
    .N_INPUTS (N_INPUTS),
    .ACC_W    (ACC_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .AG_rst     (AG_rst),
    .AG_read    (AG_read),
    .ALU_rst    (ALU_rst),
    .ALU_forget (ALU_forget),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_rdata  (mem_rdata),
    .acc_out    (acc_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .ag_done    (ag_done)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Operand memory with one cycle of read latency
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  // Scoreboard: every completed sum is compared against the oldest expected value
  always @(negedge clk) begin
    logic signed [15:0] expSum;
    if (reset) begin
      if (mem_rd_en) rdEnCount++;
      if (ag_done) agDoneCount++;
      if (out_valid) begin
        outValidCount++;
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL sum: out_valid with no expected sum, got %0d", acc_out);
        end else begin
          expSum = expQ.pop_front();
          if (acc_out !== expSum) begin
            errors++;
            $display("[TB] FAIL sum: got %0d expected %0d", acc_out, expSum);
          end
        end
        checks++;
        if (ag_done !== 1'b1) begin
          errors++;
          $display("[TB] FAIL agDoneWithValid: got %0b expected 1", ag_done);
        end
      end
    end
  end

  // Hard stop in case something blocks forever
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // One fetch-and-accumulate request; lat is the number of falling edges until busy drops
  task automatic applyStimulus(input bit holdInFetch, input bit fgtAccum, input bit fgtDone,
                               output int lat);
    lat = -1;
    @(negedge clk);
    AG_read = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      ALU_forget = 1'b0;
      AG_read = (k == 1) && holdInFetch;
      if (!busy) begin
        lat = k;
        break;
      end
      if (k == 2 && fgtAccum) ALU_forget = 1'b1;
      if (k == 3 && fgtDone) ALU_forget = 1'b1;
    end
    AG_read = 1'b0;
    ALU_forget = 1'b0;
    if (lat < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL readTimeout: busy still %0b after 12 cycles", busy);
    end
  endtask

  task automatic runNeuron(input int fgtAccumAt, input bit fgtDoneLast);
    int lat;
    for (int i = 1; i <= N_INPUTS; i++) begin
      applyStimulus(1'b0, i == fgtAccumAt, (i == N_INPUTS) && fgtDoneLast, lat);
      if (i == N_INPUTS) checkOutput("lastLatency", lat, 4);
      if (i == fgtAccumAt) checkOutput("addrAfterForget", mem_addr, i);
    end
    @(negedge clk);
  endtask

  task automatic pulseAluRst();
    @(negedge clk);
    ALU_rst = 1'b1;
    @(negedge clk);
    ALU_rst = 1'b0;
    checkOutput("aluRstAccOut", acc_out, 0);
    checkOutput("aluRstAddr", mem_addr, 0);
  endtask

  task automatic fillMem(input bit ramp, input logic signed [7:0] w, input logic signed [7:0] x);
    logic [7:0] wi;
    for (int i = 0; i < 16; i++) begin
      wi = ramp ? 8'(i + 1) : w;
      mem[i] = {wi, x};
    end
  endtask

  initial begin
    int ov0, ag0, rd0, lat;
    reset = 1'b0;
    AG_rst = 1'b0;
    AG_read = 1'b0;
    ALU_rst = 1'b0;
    ALU_forget = 1'b0;

    vecs[0] = '{8'sd2,   8'sd3,   1'b0, 16'sd96};
    vecs[1] = '{8'sd127, 8'sd127, 1'b0, 16'sd32767};
    vecs[2] = '{8'h80,   8'sd127, 1'b0, 16'h8000};
    vecs[3] = '{8'hFF,   8'sd5,   1'b0, -16'sd80};
    vecs[4] = '{8'sd0,   8'hFE,   1'b1, -16'sd272};
    vecs[5] = '{8'sd0,   8'sd100, 1'b1, 16'sd13600};

    repeat (2) @(negedge clk);
    checkOutput("rstAddr", mem_addr, 0);
    checkOutput("rstRdEn", mem_rd_en, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstAccOut", acc_out, 0);
    checkOutput("rstOutValid", out_valid, 0);
    checkOutput("rstAgDone", ag_done, 0);
    reset = 1'b1;

    foreach (vecs[v]) begin
      pulseAluRst();
      fillMem(vecs[v].ramp, vecs[v].w, vecs[v].x);
      expQ.push_back(vecs[v].exp);
      ov0 = outValidCount;
      ag0 = agDoneCount;
      rd0 = rdEnCount;
      runNeuron(0, 1'b0);
      checkOutput("outValidPulses", outValidCount - ov0, 1);
      checkOutput("agDonePulses", agDoneCount - ag0, 1);
      checkOutput("rdEnPulses", rdEnCount - rd0, 16);
      checkOutput("addrWrapped", mem_addr, 0);
    end

    pulseAluRst();
    fillMem(1'b1, 8'sd0, 8'hFE);
    expQ.push_back(-16'sd242);
    runNeuron(5, 1'b0);

    pulseAluRst();
    fillMem(1'b0, 8'sd2, 8'sd3);
    expQ.push_back(16'sd96);
    runNeuron(0, 1'b1);
    expQ.push_back(16'sd96);
    runNeuron(0, 1'b0);

    pulseAluRst();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, lat);
    checkOutput("addrBeforeAgRst", mem_addr, 3);
    rd0 = rdEnCount;
    @(negedge clk);
    AG_rst = 1'b1;
    AG_read = 1'b1;
    @(negedge clk);
    AG_rst = 1'b0;
    AG_read = 1'b0;
    checkOutput("agRstAddr", mem_addr, 0);
    checkOutput("agRstBusy", busy, 0);
    checkOutput("agRstRdEn", mem_rd_en, 0);
    @(negedge clk);
    checkOutput("agRstNoFetch", rdEnCount - rd0, 0);
    expQ.push_back(16'sd114);
    runNeuron(0, 1'b0);

    @(negedge clk);
    AG_read = 1'b1;
    @(posedge clk);
    #2;
    checkOutput("rdEnInFetch", mem_rd_en, 1);
    reset = 1'b0;
    AG_read = 1'b0;
    #1;
    checkOutput("asyncRdEn", mem_rd_en, 0);
    checkOutput("asyncBusy", busy, 0);
    checkOutput("asyncAccOut", acc_out, 0);
    checkOutput("asyncOutValid", out_valid, 0);
    checkOutput("asyncAgDone", ag_done, 0);
    checkOutput("asyncAddr", mem_addr, 0);
    @(negedge clk);
    reset = 1'b1;

    pulseAluRst();
    rd0 = rdEnCount;
    applyStimulus(1'b1, 1'b0, 1'b0, lat);
    checkOutput("heldReadLatency", lat, 3);
    repeat (3) @(negedge clk);
    checkOutput("heldReadRdEn", rdEnCount - rd0, 1);
    checkOutput("heldReadAddr", mem_addr, 1);
    checkOutput("heldReadBusy", busy, 0);

    checkOutput("scoreboardDrained", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
